// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared constants and types for the clock display scan path.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam logic [2:0] SLOT_LO_ONES = 3'd0;
    localparam logic [2:0] SLOT_LO_TENS = 3'd2;
    localparam logic [2:0] SLOT_HI_ONES = 3'd4;
    localparam logic [2:0] SLOT_HI_TENS = 3'd6;

    localparam logic [3:0] BLANK_PATTERN = 4'b0000;

    typedef enum logic [1:0] {
        CONV_IDLE = 2'd0,
        CONV_LOAD = 2'd1,
        CONV_SUB  = 2'd2,
        CONV_DONE = 2'd3
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/bin6_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin6_to_bcd_seq
// Description : Repeated-subtract binary (0-63) to two-digit BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module bin6_to_bcd_seq
    import clock_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    conv_state_t r_state;
    logic [5:0]  r_work;
    logic [3:0]  r_tens;
    logic [5:0]  w_work_sub;

    assign w_work_sub = r_work - 6'd10;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= CONV_IDLE;
            r_work  <= 6'd0;
            r_tens  <= 4'd0;
        end else begin
            case (r_state)
                CONV_IDLE, CONV_DONE: begin
                    if (start) begin
                        r_state <= CONV_LOAD;
                    end
                end
                CONV_LOAD: begin
                    r_work  <= bin;
                    r_tens  <= 4'd0;
                    r_state <= CONV_SUB;
                end
                CONV_SUB: begin
                    // Finishing on the last subtraction keeps 63 within seven cycles of start.
                    if (r_work >= 6'd10) begin
                        r_work <= w_work_sub;
                        r_tens <= r_tens + 4'd1;
                        if (w_work_sub < 6'd10) begin
                            r_state <= CONV_DONE;
                        end
                    end else begin
                        r_state <= CONV_DONE;
                    end
                end
                default: r_state <= CONV_IDLE;
            endcase
        end
    end

    assign tens = r_tens;
    assign ones = r_work[3:0];
    assign done = (r_state == CONV_DONE);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : 8-slot scan scheduler for the 4-digit 7-segment clock display.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import clock_pkg::*;
#(
    parameter int DIV        = 1024,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [11:0] data_show,
    input  logic [3:0]  blink_mask,
    output logic [2:0]  byte_status,
    output logic [3:0]  digit_en,
    output logic [3:0]  digit_bcd,
    output logic        frame_start
);

    localparam int                 c_PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(DIV - 1);
    localparam int                 c_FRM_W    = BLINK_LOG2 + 1;

    logic [c_PRE_W-1:0] r_pre;
    logic [2:0]         r_slot;
    logic [c_FRM_W-1:0] r_frame;
    logic               r_run;
    logic [11:0]        r_shadow;
    logic [3:0][3:0]    r_disp;
    logic [3:0]         r_digit_en;
    logic [3:0]         r_digit_bcd;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_snap;
    logic               w_commit;
    logic [2:0]         w_slot_nxt;
    logic [c_FRM_W-1:0] w_frame_nxt;
    logic [3:0][3:0]    w_disp_nxt;
    logic [1:0][3:0]    w_tens;
    logic [1:0][3:0]    w_ones;
    logic [1:0]         w_done;
    logic [3:0]         w_en_raw;
    logic [3:0]         w_bcd_dec;
    logic [3:0]         w_blink_off;
    logic [3:0]         w_en_dec;

    assign w_tick      = scan_en && (r_pre == c_PRE_LAST);
    assign w_snap      = w_tick && (r_slot == 3'd6);
    assign w_commit    = w_tick && (r_slot == 3'd7);
    assign w_slot_nxt  = w_tick ? (r_slot + 3'd1) : r_slot;
    assign w_frame_nxt = w_commit ? (r_frame + 1'b1) : r_frame;

    // A late converter keeps the previous frame's digits rather than tearing.
    assign w_disp_nxt = (w_commit && (&w_done))
                      ? {w_tens[1], w_ones[1], w_tens[0], w_ones[0]}
                      : r_disp;

    for (genvar gi = 0; gi < 2; gi++) begin : g_field
        bin6_to_bcd_seq u_conv (
            .clock (clock),
            .reset (reset),
            .start (w_snap),
            .bin   (r_shadow[6*gi +: 6]),
            .tens  (w_tens[gi]),
            .ones  (w_ones[gi]),
            .done  (w_done[gi])
        );
    end

    always_comb begin
        w_en_raw  = BLANK_PATTERN;
        w_bcd_dec = 4'd0;
        case (w_slot_nxt)
            SLOT_LO_ONES: begin w_en_raw = 4'b0001; w_bcd_dec = w_disp_nxt[0]; end
            SLOT_LO_TENS: begin w_en_raw = 4'b0010; w_bcd_dec = w_disp_nxt[1]; end
            SLOT_HI_ONES: begin w_en_raw = 4'b0100; w_bcd_dec = w_disp_nxt[2]; end
            SLOT_HI_TENS: begin w_en_raw = 4'b1000; w_bcd_dec = w_disp_nxt[3]; end
            default: ;
        endcase
    end

    // Outputs are registered from next-state values so they line up with byte_status.
    assign w_blink_off = blink_mask & {4{w_frame_nxt[BLINK_LOG2]}};
    assign w_en_dec    = (scan_en && (r_run || w_tick)) ? (w_en_raw & ~w_blink_off)
                                                        : BLANK_PATTERN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre         <= '0;
            r_slot        <= 3'd0;
            r_frame       <= '0;
            r_run         <= 1'b0;
            r_shadow      <= 12'd0;
            r_disp        <= '0;
            r_digit_en    <= BLANK_PATTERN;
            r_digit_bcd   <= 4'd0;
            r_frame_start <= 1'b0;
        end else begin
            if (scan_en) begin
                r_pre <= w_tick ? '0 : (r_pre + 1'b1);
            end
            if (w_tick) begin
                r_run <= 1'b1;
            end
            if (w_snap) begin
                r_shadow <= data_show;
            end
            r_slot        <= w_slot_nxt;
            r_frame       <= w_frame_nxt;
            r_disp        <= w_disp_nxt;
            r_digit_en    <= w_en_dec;
            r_digit_bcd   <= w_bcd_dec;
            r_frame_start <= w_commit;
        end
    end

    assign byte_status = r_slot;
    assign digit_en    = r_digit_en;
    assign digit_bcd   = r_digit_bcd;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl with DIV=8, BLINK_LOG2=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int c_DIV        = 8;
    localparam int c_BLINK_LOG2 = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        scan_en = 1'b0;
    logic [11:0] data_show = 12'd0;
    logic [3:0]  blink_mask = 4'd0;
    logic [2:0]  byte_status;
    logic [3:0]  digit_en;
    logic [3:0]  digit_bcd;
    logic        frame_start;

    display_scan_ctrl #(.DIV(c_DIV), .BLINK_LOG2(c_BLINK_LOG2)) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_en     (scan_en),
        .data_show   (data_show),
        .blink_mask  (blink_mask),
        .byte_status (byte_status),
        .digit_en    (digit_en),
        .digit_bcd   (digit_bcd),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] slot;
        logic [3:0] en;
        logic [3:0] bcd;
        logic       fs;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_slot, m_frame;
    logic [11:0] m_snap;
    logic [3:0] m_disp[4];

    function automatic void model_reset();
        m_slot  = 0;
        m_frame = 0;
        m_snap  = 12'd0;
        for (int i = 0; i < 4; i++) m_disp[i] = 4'd0;
        sb_q.delete();
    endfunction

    // Predict the next slot entry from the behavioural frame model.
    function automatic void push_next_slot();
        exp_t e;
        int   d;
        m_slot = (m_slot + 1) % 8;
        if (m_slot == 7) m_snap = data_show;
        if (m_slot == 0) begin
            m_frame++;
            m_disp[0] = 4'(m_snap[5:0] % 10);
            m_disp[1] = 4'(m_snap[5:0] / 10);
            m_disp[2] = 4'(m_snap[11:6] % 10);
            m_disp[3] = 4'(m_snap[11:6] / 10);
        end
        e.slot = 3'(m_slot);
        e.fs   = (m_slot == 0);
        if (m_slot % 2 == 0) begin
            d     = m_slot / 2;
            e.en  = 4'(1 << d);
            e.bcd = m_disp[d];
            if (((m_frame >> c_BLINK_LOG2) & 1) == 1 && blink_mask[d]) e.en = 4'd0;
        end else begin
            e.en  = 4'd0;
            e.bcd = 4'd0;
        end
        sb_q.push_back(e);
    endfunction

    task automatic wait_slot(output bit to, output int dt);
        logic [2:0] prev;
        int         c0;
        prev = byte_status;
        c0   = cyc;
        to   = 1'b1;
        repeat (200) begin
            @(negedge clock);
            if (byte_status !== prev) begin
                to = 1'b0;
                break;
            end
        end
        dt = cyc - c0;
    endtask

    task automatic test_reset();
        scan_en   = 1'b1;
        data_show = {6'd12, 6'd34};
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({byte_status, digit_en, digit_bcd, frame_start} !== 12'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got bs=%0d en=%b bcd=%0d fs=%b, expected all 0",
                         byte_status, digit_en, digit_bcd, frame_start);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_first_frame(input string name);
        exp_t e;
        bit   to;
        int   dt, c0;
        bit   seen_fs;
        reset = 1'b1;
        c0 = cyc;
        model_reset();
        seen_fs = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            n_vec++;
            if (byte_status !== 3'd0 || digit_en !== 4'd0) begin
                n_err++;
                $display("FAIL %s_dark_slot0 cyc%0d: got bs=%0d en=%b, expected bs=0 en=0000",
                         name, i, byte_status, digit_en);
            end
        end
        for (int i = 0; i < 15; i++) begin
            push_next_slot();
            wait_slot(to, dt);
            e = sb_q.pop_front();
            n_vec++;
            if (to) begin
                n_err++;
                $display("FAIL %s_timeout: no slot change, expected slot %0d", name, e.slot);
            end else if ({byte_status, digit_en, digit_bcd, frame_start} !== e) begin
                n_err++;
                $display("FAIL %s_slot: got bs=%0d en=%b bcd=%0d fs=%b, expected bs=%0d en=%b bcd=%0d fs=%b",
                         name, byte_status, digit_en, digit_bcd, frame_start, e.slot, e.en, e.bcd, e.fs);
            end
            if (i > 0) begin
                n_vec++;
                if (dt !== c_DIV) begin
                    n_err++;
                    $display("FAIL %s_slot_len: got %0d cycles, expected %0d", name, dt, c_DIV);
                end
            end
            if (e.fs && !seen_fs) begin
                seen_fs = 1'b1;
                n_vec++;
                if (cyc - c0 !== 8 * c_DIV) begin
                    n_err++;
                    $display("FAIL %s_first_frame_start: got %0d cycles, expected %0d",
                             name, cyc - c0, 8 * c_DIV);
                end
            end
        end
    endtask

    // Generic scoreboard run of n slots; data changes at a chosen frame/slot.
    task automatic run_slots(input string name, input int n, input int chg_frame,
                             input int chg_slot, input logic [11:0] chg_data);
        exp_t e;
        bit   to;
        int   dt;
        for (int i = 0; i < n; i++) begin
            push_next_slot();
            wait_slot(to, dt);
            e = sb_q.pop_front();
            n_vec++;
            if (to) begin
                n_err++;
                $display("FAIL %s_timeout: no slot change, expected slot %0d", name, e.slot);
            end else if ({byte_status, digit_en, digit_bcd, frame_start} !== e) begin
                n_err++;
                $display("FAIL %s_slot: got bs=%0d en=%b bcd=%0d fs=%b, expected bs=%0d en=%b bcd=%0d fs=%b",
                         name, byte_status, digit_en, digit_bcd, frame_start, e.slot, e.en, e.bcd, e.fs);
            end
            if (m_frame == chg_frame && m_slot == chg_slot) data_show = chg_data;
        end
    endtask

    task automatic test_max_value();
        data_show = 12'hFFF;
        run_slots("max63", 16, -1, -1, 12'd0);
    endtask

    task automatic test_no_tear();
        data_show = {6'd5, 6'd5};
        run_slots("no_tear", 24, 5, 3, {6'd59, 6'd59});
    endtask

    task automatic test_blink();
        blink_mask = 4'b1000;
        run_slots("blink", 40, -1, -1, 12'd0);
        blink_mask = 4'b0000;
    endtask

    task automatic test_scan_pause();
        exp_t e;
        bit   to, bad;
        int   dt;
        for (int i = 0; i < 8 && m_slot != 4; i++) begin
            push_next_slot();
            wait_slot(to, dt);
            e = sb_q.pop_front();
            n_vec++;
            if (to || {byte_status, digit_en, digit_bcd, frame_start} !== e) begin
                n_err++;
                $display("FAIL pause_sync: got bs=%0d en=%b bcd=%0d fs=%b, expected bs=%0d en=%b bcd=%0d fs=%b",
                         byte_status, digit_en, digit_bcd, frame_start, e.slot, e.en, e.bcd, e.fs);
            end
        end
        repeat (3) @(negedge clock);
        scan_en = 1'b0;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (byte_status !== 3'd4 || digit_en !== 4'd0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL pause_hold: got bs=%0d en=%b, expected bs=4 en=0000", byte_status, digit_en);
        end
        scan_en = 1'b1;
        @(negedge clock);
        n_vec++;
        if (digit_en !== 4'b0100 || byte_status !== 3'd4) begin
            n_err++;
            $display("FAIL pause_resume_en: got bs=%0d en=%b, expected bs=4 en=0100", byte_status, digit_en);
        end
        push_next_slot();
        wait_slot(to, dt);
        e = sb_q.pop_front();
        n_vec++;
        if (to || dt !== 4) begin
            n_err++;
            $display("FAIL pause_remaining: got %0d cycles to slot 5, expected 4", dt);
        end
        n_vec++;
        if ({byte_status, digit_en, digit_bcd, frame_start} !== e) begin
            n_err++;
            $display("FAIL pause_slot5: got bs=%0d en=%b bcd=%0d fs=%b, expected bs=%0d en=%b bcd=%0d fs=%b",
                     byte_status, digit_en, digit_bcd, frame_start, e.slot, e.en, e.bcd, e.fs);
        end
    endtask

    task automatic test_reset_mid_conv();
        data_show = 12'hFFF;
        run_slots("pre_reset", 2, -1, -1, 12'd0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({byte_status, digit_en, digit_bcd, frame_start} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_async: got bs=%0d en=%b bcd=%0d fs=%b, expected all 0",
                     byte_status, digit_en, digit_bcd, frame_start);
        end
        repeat (2) @(negedge clock);
        test_first_frame("after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_frame("first_frame");
        test_max_value();
        test_no_tear();
        test_blink();
        test_scan_pause();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
